// File: rtl/csr_pkg.sv
// csr_pkg: shared widths, FPU flag address, op and FSM encodings for the CSR sequencer
package csr_pkg;
  localparam int CSR_ADDR_W = 12;
  localparam int CSR_DATA_W = 32;
  localparam logic [11:0] CSR_FFLAGS_ADDR = 12'h001;
  typedef enum logic [1:0] {OP_RW = 2'b00, OP_RS = 2'b01, OP_RC = 2'b10, OP_RD = 2'b11} csr_op_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} csr_state_e;
endpackage

// File: rtl/csr_rr_arbiter.sv
// csr_rr_arbiter: 2-way round-robin between core (bit 0) and FPU (bit 1)
module csr_rr_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  // last_q=1 means the FPU was granted last, so the core wins the next tie
  always_comb begin
    gnt = !en ? 2'b00 : (&req) ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = |gnt ? gnt[1] : last_q;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer: serialises core CSR ops and FPU flag accrual into read-modify-write sequences
module csr_access_sequencer
  import csr_pkg::*;
#(
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int DATA_W = CSR_DATA_W,
  parameter logic [ADDR_W-1:0] FFLAGS_ADDR = ADDR_W'(CSR_FFLAGS_ADDR)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_req_op,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_resp_valid,
  input  logic              core_resp_ready,
  output logic [DATA_W-1:0] core_resp_rdata,
  output logic              core_resp_err,
  input  logic              fpu_acc_valid,
  output logic              fpu_acc_ready,
  input  logic [4:0]        fpu_acc_flags,
  output logic              csr_read_enable,
  output logic [ADDR_W-1:0] csr_read_select,
  input  logic [DATA_W-1:0] csr_read_data,
  output logic              csr_write_enable,
  output logic [ADDR_W-1:0] csr_write_select,
  output logic [DATA_W-1:0] csr_write_data
);
  csr_state_e state_q, state_d;
  csr_op_e op_q, op_d;
  logic fpu_q, fpu_d, re_q, re_d, we_q, we_d, rv_q, rv_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, old_q, old_d, wr_q, wr_d, new_val;
  logic [1:0] gnt;
  logic noop, illegal;
  csr_rr_arbiter u_arb (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (state_q == S_IDLE && RESET),
    .req  ({fpu_acc_valid, core_req_valid}),
    .gnt  (gnt)
  );
  assign core_req_ready   = gnt[0];
  assign fpu_acc_ready    = gnt[1];
  assign core_resp_valid  = rv_q;
  assign core_resp_rdata  = old_q;
  assign core_resp_err    = err_q;
  assign csr_read_enable  = re_q;
  assign csr_read_select  = addr_q;
  assign csr_write_enable = we_q;
  assign csr_write_select = addr_q;
  assign csr_write_data   = wr_q;
  // FPU accrual is latched as an RS of the flags onto FFLAGS_ADDR and never faults
  always_comb begin
    noop    = op_q == OP_RD || (op_q != OP_RW && wdata_q == '0);
    illegal = !fpu_q && !noop && addr_q[ADDR_W-1 -: 2] == 2'b11;
    new_val = op_q == OP_RW ? wdata_q : op_q == OP_RS ? (csr_read_data | wdata_q) : (csr_read_data & ~wdata_q);
    state_d = state_q;
    op_d    = op_q;
    fpu_d   = fpu_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    wr_d    = wr_q;
    err_d   = err_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    if (state_q == S_IDLE && |gnt) begin
      state_d = S_READ;
      fpu_d   = gnt[1];
      op_d    = gnt[1] ? OP_RS : csr_op_e'(core_req_op);
      addr_d  = gnt[1] ? FFLAGS_ADDR : core_req_addr;
      wdata_d = gnt[1] ? DATA_W'(fpu_acc_flags) : core_req_wdata;
      err_d   = 1'b0;
      re_d    = 1'b1;
    end
    if (state_q == S_READ) begin
      state_d = S_WRITE;
      old_d   = csr_read_data;
      wr_d    = new_val;
      we_d    = !noop && !illegal;
      err_d   = illegal;
    end
    if (state_q == S_WRITE) state_d = fpu_q ? S_IDLE : S_RESP;
    if (state_q == S_RESP && core_resp_ready) state_d = S_IDLE;
    rv_d = state_d == S_RESP;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      op_q    <= OP_RW;
      fpu_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      wr_q    <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fpu_q   <= fpu_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      wr_q    <= wr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_csr_access_sequencer.sv
// tb_csr_access_sequencer: transaction-level model of the sequencer plus a CSR file, checked every cycle
module tb_csr_access_sequencer;
  logic        CLK = 1'b0, RESET = 1'b0;
  logic        core_req_valid = 0, core_req_ready, core_resp_valid, core_resp_ready = 0, core_resp_err;
  logic [1:0]  core_req_op = 0;
  logic [11:0] core_req_addr = 0, csr_read_select, csr_write_select;
  logic [31:0] core_req_wdata = 0, core_resp_rdata, csr_read_data, csr_write_data;
  logic        fpu_acc_valid = 0, fpu_acc_ready, csr_read_enable, csr_write_enable;
  logic [4:0]  fpu_acc_flags = 0;
  logic [31:0] mem [4096];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit busy = 0, last_fpu = 1, m_fpu, m_we, m_err;
  int t_acc = 0;
  logic [11:0] m_addr;
  logic [31:0] m_old, m_new;

  csr_access_sequencer dut (
    .CLK(CLK), .RESET(RESET),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_op(core_req_op),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_rdata(core_resp_rdata), .core_resp_err(core_resp_err),
    .fpu_acc_valid(fpu_acc_valid), .fpu_acc_ready(fpu_acc_ready), .fpu_acc_flags(fpu_acc_flags),
    .csr_read_enable(csr_read_enable), .csr_read_select(csr_read_select), .csr_read_data(csr_read_data),
    .csr_write_enable(csr_write_enable), .csr_write_select(csr_write_select), .csr_write_data(csr_write_data)
  );

  assign csr_read_data = mem[csr_read_select];
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted op reads at +1, writes at +2, responds from +3 until the handshake
  always @(negedge CLK) begin : model
    int d;
    bit cw, fw, rv, nop;
    logic [31:0] w;
    logic [1:0] op;
    if (!RESET) begin
      chk("rst_core_req_ready", core_req_ready, 0);
      chk("rst_fpu_acc_ready", fpu_acc_ready, 0);
      chk("rst_resp_valid", core_resp_valid, 0);
      chk("rst_resp_rdata", core_resp_rdata, 0);
      chk("rst_resp_err", core_resp_err, 0);
      chk("rst_read_enable", csr_read_enable, 0);
      chk("rst_write_enable", csr_write_enable, 0);
      busy = 0;
      last_fpu = 1;
    end else begin
      d  = cyc - t_acc;
      cw = !busy && core_req_valid && (!fpu_acc_valid || last_fpu);
      fw = !busy && fpu_acc_valid && !cw;
      chk("core_req_ready", core_req_ready, cw);
      chk("fpu_acc_ready", fpu_acc_ready, fw);
      chk("csr_read_enable", csr_read_enable, busy && d == 1);
      if (busy && d == 1) chk("csr_read_select", csr_read_select, m_addr);
      chk("csr_write_enable", csr_write_enable, busy && d == 2 && m_we);
      if (busy && d == 2 && m_we) begin
        chk("csr_write_select", csr_write_select, m_addr);
        chk("csr_write_data", csr_write_data, m_new);
        mem[m_addr] = m_new;
      end
      rv = busy && !m_fpu && d >= 3;
      chk("core_resp_valid", core_resp_valid, rv);
      if (rv) begin
        chk("core_resp_rdata", core_resp_rdata, m_old);
        chk("core_resp_err", core_resp_err, m_err);
      end
      if (busy && (m_fpu ? d == 2 : (rv && core_resp_ready))) busy = 0;
      else if (cw || fw) begin
        busy = 1;
        t_acc = cyc;
        m_fpu = fw;
        last_fpu = fw;
        m_addr = fw ? 12'h001 : core_req_addr;
        w  = fw ? {27'b0, fpu_acc_flags} : core_req_wdata;
        op = fw ? 2'b01 : core_req_op;
        m_old = mem[m_addr];
        m_new = op == 2'b00 ? w : op == 2'b01 ? (m_old | w) : (m_old & ~w);
        nop = op == 2'b11 || (op != 2'b00 && w == 0);
        m_err = !fw && !nop && m_addr[11:10] == 2'b11;
        m_we = !nop && !m_err;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 0;
    core_req_valid = 0;
    fpu_acc_valid = 0;
    repeat (3) tick();
    RESET = 1;
  endtask

  task automatic wait_ready(input bit fpu);
    int n = 0;
    @(negedge CLK);
    while (!(fpu ? fpu_acc_ready : core_req_ready) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got no ready expected ready within 50 cycles (fpu=%0d)", fpu);
    end
  endtask

  task automatic core_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                         output logic we, output logic [31:0] wdat, output logic [11:0] wsel,
                         output logic rv, output logic [31:0] rd, output logic er);
    core_req_valid = 1;
    core_req_op = op;
    core_req_addr = a;
    core_req_wdata = wd;
    core_resp_ready = 1;
    wait_ready(0);
    tick();
    core_req_valid = 0;
    @(negedge CLK);
    @(negedge CLK);
    we = csr_write_enable;
    wdat = csr_write_data;
    wsel = csr_write_select;
    @(negedge CLK);
    rv = core_resp_valid;
    rd = core_resp_rdata;
    er = core_resp_err;
    tick();
  endtask

  initial begin
    logic we, rv, er;
    logic [31:0] wdat, rd, rd0, pre;
    logic [11:0] wsel;
    logic [11:0] addrs [6];
    addrs = '{12'h300, 12'h001, 12'hC00, 12'hC01, 12'h340, 12'hBFF};
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    repeat (3) tick();
    RESET = 1;
    tick();
    mem[12'h300] = 32'h1;
    core_op(2'b01, 12'h300, 32'h8, we, wdat, wsel, rv, rd, er);
    chk("rs_write_enable", we, 1);
    chk("rs_write_data", wdat, 32'h9);
    chk("rs_write_select", wsel, 12'h300);
    chk("rs_resp_valid", rv, 1);
    chk("rs_resp_rdata", rd, 32'h1);
    chk("rs_resp_err", er, 0);
    chk("model_csr_300", mem[12'h300], 32'h9);
    core_op(2'b10, 12'h300, 32'h0, we, wdat, wsel, rv, rd, er);
    chk("rc0_write_enable", we, 0);
    chk("rc0_resp_rdata", rd, 32'h9);
    chk("rc0_resp_err", er, 0);
    core_op(2'b00, 12'hC00, 32'h5A5A, we, wdat, wsel, rv, rd, er);
    chk("ro_rw_write_enable", we, 0);
    chk("ro_rw_resp_err", er, 1);
    core_op(2'b11, 12'hC00, 32'h5A5A, we, wdat, wsel, rv, rd, er);
    chk("ro_rd_resp_err", er, 0);
    chk("ro_rd_resp_valid", rv, 1);
    do_reset();
    mem[12'h001] = 32'h2;
    core_req_valid = 1;
    core_req_op = 2'b11;
    core_req_addr = 12'h300;
    core_resp_ready = 1;
    fpu_acc_valid = 1;
    fpu_acc_flags = 5'h05;
    @(negedge CLK);
    chk("tie1_core_ready", core_req_ready, 1);
    chk("tie1_fpu_ready", fpu_acc_ready, 0);
    tick();
    core_req_valid = 0;
    wait_ready(1);
    tick();
    fpu_acc_valid = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("fpu_write_enable", csr_write_enable, 1);
    chk("fpu_write_select", csr_write_select, 12'h001);
    chk("fpu_write_data", csr_write_data, 32'h7);
    tick();
    core_req_valid = 1;
    fpu_acc_valid = 1;
    @(negedge CLK);
    chk("tie2_core_ready", core_req_ready, 1);
    chk("tie2_fpu_ready", fpu_acc_ready, 0);
    tick();
    core_req_valid = 0;
    fpu_acc_valid = 0;
    repeat (5) tick();
    chk("model_fflags", mem[12'h001], 32'h7);
    core_resp_ready = 0;
    core_req_valid = 1;
    core_req_op = 2'b00;
    core_req_addr = 12'h340;
    core_req_wdata = 32'hCAFE0001;
    wait_ready(0);
    tick();
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("hold_resp_valid_first", core_resp_valid, 1);
    rd0 = core_resp_rdata;
    repeat (5) begin
      @(negedge CLK);
      chk("hold_resp_valid", core_resp_valid, 1);
      chk("hold_resp_rdata", core_resp_rdata, rd0);
      chk("hold_no_ready", core_req_ready, 0);
    end
    tick();
    core_resp_ready = 1;
    @(negedge CLK);
    chk("handshake_no_ready", core_req_ready, 0);
    tick();
    @(negedge CLK);
    chk("after_handshake_ready", core_req_ready, 1);
    tick();
    core_req_valid = 0;
    repeat (5) tick();
    pre = mem[12'h300];
    core_req_valid = 1;
    core_req_op = 2'b00;
    core_req_addr = 12'h300;
    core_req_wdata = ~pre;
    wait_ready(0);
    tick();
    core_req_valid = 0;
    tick();
    chk("pre_reset_write_enable", csr_write_enable, 1);
    RESET = 0;
    #1;
    chk("async_write_enable_drop", csr_write_enable, 0);
    chk("async_resp_valid", core_resp_valid, 0);
    repeat (2) tick();
    RESET = 1;
    repeat (5) begin
      @(negedge CLK);
      chk("no_resp_after_reset", core_resp_valid, 0);
    end
    chk("model_discard_write", mem[12'h300], pre);
    tick();
    repeat (3000) begin
      tick();
      RESET = $urandom_range(0, 499) != 0;
      core_req_valid = $urandom_range(0, 1);
      core_req_op = 2'($urandom_range(0, 3));
      core_req_addr = addrs[$urandom_range(0, 5)];
      core_req_wdata = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
      fpu_acc_valid = $urandom_range(0, 1);
      fpu_acc_flags = $urandom_range(0, 3) == 0 ? 5'h0 : 5'($urandom);
      core_resp_ready = $urandom_range(0, 1);
    end
    tick();
    RESET = 1;
    core_req_valid = 0;
    fpu_acc_valid = 0;
    core_resp_ready = 1;
    repeat (10) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/csr_access_sequencer.md
CSR_ACCESS_SEQUENCER -- requirements
Module: csr_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, CSR select width.
REQ-002 SHALL have parameter DATA_W, default 32, CSR data width.
REQ-003 SHALL have parameter FFLAGS_ADDR, default 12'h001, target address of FPU flag accrual.
REQ-004 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have core_req_valid / core_req_ready  in / out  1 each  core request handshake.
REQ-007 SHALL have core_req_op  in  2  00 RW, 01 RS (set), 10 RC (clear), 11 RD (read only).
REQ-008 SHALL have core_req_addr  in  ADDR_W  CSR select; core_req_wdata  in  DATA_W  operand.
REQ-009 SHALL have core_resp_valid / core_resp_ready  out / in  1 each  core response handshake.
REQ-010 SHALL have core_resp_rdata  out  DATA_W  old CSR value; core_resp_err  out  1  illegal write.
REQ-011 SHALL have fpu_acc_valid / fpu_acc_ready  in / out  1 each; fpu_acc_flags  in  5  flags to OR in.
REQ-012 SHALL have csr_read_enable  out  1; csr_read_select  out  ADDR_W; csr_read_data  in  DATA_W (combinational).
REQ-013 SHALL have csr_write_enable  out  1; csr_write_select  out  ADDR_W; csr_write_data  out  DATA_W.

Function
REQ-014 FSM states IDLE, READ, WRITE, RESP; one operation in flight at most.
REQ-015 Ready asserted only in IDLE, only to the arbitration winner; request accepted on valid&ready edge; operands registered.
REQ-016 Arbitration round-robin: when both valid, winner is the source not granted last; first grant after reset goes to core; sole requester always wins.
REQ-017 READ (1 cycle): csr_read_enable=1, csr_read_select=latched addr (FFLAGS_ADDR for FPU); csr_read_data captured as old.
REQ-018 WRITE (1 cycle): new = wdata (RW), old|wdata (RS), old&~wdata (RC), old|{27'b0,flags} (FPU); csr_write_enable=1 with select/data.
REQ-019 Write suppressed (enable=0) for RD, for RS/RC with wdata==0, and for FPU with flags==0; state sequence unchanged.
REQ-020 Core write (op!=RD and write not suppressed) to addr[11:10]==2'b11 SHALL be suppressed and core_resp_err=1; otherwise err=0.
REQ-021 Core ops: WRITE -> RESP; core_resp_valid=1 with rdata=old, held stable until core_resp_ready, then IDLE. Accept-to-resp_valid latency exactly 3 cycles.
REQ-022 FPU ops: WRITE -> IDLE; no response; accept-to-write latency exactly 2 cycles.
REQ-023 core_resp_ready asserted on the cycle resp_valid rises completes immediately; IDLE next cycle, new accept possible then.
REQ-024 Outside READ/WRITE, csr_read_enable and csr_write_enable SHALL be 0; selects/data don't-care but registered-stable.

Reset
REQ-025 RESET low SHALL immediately force IDLE, all outputs 0, last-grant=FPU (so core wins first), discarding any in-flight op with no write issued.
REQ-026 Outputs SHALL stay 0 while RESET low; normal operation from first rising CLK after release.

Structure
REQ-027 Shared package csr_pkg SHALL hold ADDR_W/DATA_W defaults, FFLAGS_ADDR, op encoding enum, FSM state enum.
REQ-028 One sub-module csr_rr_arbiter (2-way round-robin, grant + last-grant register); rest flat.

Verification
REQ-029 Core RS addr 0x300 wdata 0x8, CSR holds 0x1 -> write 0x9 at accept+2, resp rdata 0x1 err 0 at accept+3.
REQ-030 Core RC addr 0x300 wdata 0 -> no csr_write_enable, resp rdata = old value, err 0.
REQ-031 Core RW addr 0xC00 -> no write, resp err 1; core RD addr 0xC00 -> err 0.
REQ-032 Core and FPU (flags 0x05, fflags old 0x02) valid same cycle after reset -> core first, then FPU writes 0x07 to 0x001; next tie -> core wins again.
REQ-033 Resp with resp_ready low 5 cycles -> resp_valid/rdata held, no new ready until handshake.
REQ-034 RESET asserted during WRITE of RW -> write_enable drops asynchronously, FSM IDLE, no resp_valid after release.
